lsu_ctrl: RTL and testbench

- Load/store unit: the initiator side of the single-ported word data memory.
- Accepts one RV32I load/store request at a time from the execute stage and drives the memory strobes, address and write data.
- Performs byte-lane extraction with sign/zero extension for loads, and read-modify-write for sub-word stores.
- Returns one response per request; misaligned, out-of-range and illegal accesses are flagged as errors.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_align.sv | 37 +++
 rtl/lsu_ctrl.sv | 166 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
// Holds funct3 encodings, the controller state type and the funct3 legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_e;

  // Stores only know B/H/W; loads additionally have the unsigned B/H forms.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) begin
      return f3 > F3_W;
    end
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extends load data from a memory word and merges
// sub-word store data into a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{addr_lo_i, 3'b000} +: 8];
    half_v = word_i[{addr_lo_i[1], 4'b0000} +: 16];

    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_data_o = {24'h0, byte_v};
      F3_H:    load_data_o = {{16{half_v[15]}}, half_v};
      F3_HU:   load_data_o = {16'h0, half_v};
      default: load_data_o = word_i;
    endcase

    store_word_o = word_i;
    case (funct3_i)
      F3_B:    store_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H:    store_word_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time, drives a single-ported
// word memory with registered strobes and returns one response per request.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 16
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        MemWrite_o,
  output logic        MemRead_o,
  output logic [31:0] MemAddr_o,
  output logic [31:0] MemWData_o,
  input  logic [31:0] MemData_i
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_SIZE * 4);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        accept;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_word;

  // The memory word is only consumed in RD, which is when MemData_i is valid.
  lsu_align u_align (
    .funct3_i     (f3_q),
    .addr_lo_i    (addr_q[1:0]),
    .word_i       (MemData_i),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  assign accept  = req_valid_i && (state_q == IDLE);
  assign req_err = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0])
                 || ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00))
                 || (req_addr_i >= ADDR_LIMIT)
                 || f3_illegal(req_we_i, req_funct3_i);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    f3_d         = f3_q;
    wdata_d      = wdata_q;
    mem_wdata_d  = mem_wdata_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr_i;
          we_d    = req_we_i;
          f3_d    = req_funct3_i;
          wdata_d = req_wdata_i;
          if (req_err) begin
            state_d      = RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (!req_we_i || (req_funct3_i != F3_W)) begin
            state_d = RD;
          end else begin
            state_d     = WR;
            mem_wdata_d = req_wdata_i;
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_d     = WR;
          mem_wdata_d = store_word;
        end else begin
          state_d      = RESP;
          resp_rdata_d = load_data;
          resp_err_d   = 1'b0;
        end
      end
      WR: begin
        state_d      = RESP;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d      = IDLE;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered decodes of the state being entered.
    mem_read_d   = (state_d == RD);
    mem_write_d  = (state_d == WR);
    resp_valid_d = (state_d == RESP);
    mem_addr_d   = (mem_read_d || mem_write_d) ? {addr_d[31:2], 2'b00} : '0;
    if (!mem_write_d) begin
      mem_wdata_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      wdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      wdata_q      <= wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign MemRead_o    = mem_read_q;
  assign MemWrite_o   = mem_write_q;
  assign MemAddr_o    = mem_addr_q;
  assign MemWData_o   = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural word memory and a response scoreboard.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk;
  logic        reset_ni;
  logic        req_valid;
  logic        req_ready_o;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid_o;
  logic        resp_ready;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        MemWrite_o;
  logic        MemRead_o;
  logic [31:0] MemAddr_o;
  logic [31:0] MemWData_o;
  logic [31:0] MemData_i;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [16];
  int          total = 0;
  int          bad   = 0;
  int          wr_total = 0;

  lsu_ctrl #(.MEM_SIZE(16)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .MemWrite_o   (MemWrite_o),
    .MemRead_o    (MemRead_o),
    .MemAddr_o    (MemAddr_o),
    .MemWData_o   (MemWData_o),
    .MemData_i    (MemData_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign MemData_i = mem[MemAddr_o[5:2]];

  always @(posedge clk) begin
    if (MemWrite_o) begin
      mem[MemAddr_o[5:2]] <= MemWData_o;
      wr_total <= wr_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference load extraction written with shifts, independent of the DUT.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] s;
    s = w >> (a * 8);
    case (f3)
      F3_B:  return {{24{s[7]}}, s[7:0]};
      F3_BU: return s & 32'h0000_00FF;
      F3_H:  begin s = w >> (a[1] * 16); return {{16{s[15]}}, s[15:0]}; end
      F3_HU: begin s = w >> (a[1] * 16); return s & 32'h0000_FFFF; end
      default: return w;
    endcase
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input logic [31:0] exp_ww, input int hold);
    exp_t        e;
    int          lat, rds, wrs, exp_rds, exp_wrs;
    logic [31:0] seen_rd, seen_ww;
    e.rd  = exp_rd;
    e.err = exp_err;
    sb.push_back(e);
    exp_rds = (!exp_err && (!we || f3 != F3_W)) ? 1 : 0;
    exp_wrs = (!exp_err && we) ? 1 : 0;
    resp_ready = (hold == 0);
    @(negedge clk);
    chk("ready_before_req", {31'b0, req_ready_o}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFC;
    req_wdata = $urandom;
    lat = 0; rds = 0; wrs = 0; seen_ww = '0;
    do begin
      @(negedge clk);
      lat++;
      if (MemRead_o) begin
        rds++;
        chk("rd_addr", MemAddr_o, {addr[31:2], 2'b00});
      end
      if (MemWrite_o) begin
        wrs++;
        seen_ww = MemWData_o;
        chk("wr_addr", MemAddr_o, {addr[31:2], 2'b00});
      end
    end while (!resp_valid_o && lat < 10);
    chk("latency", lat, exp_lat);
    e = sb.pop_front();
    chk("rdata", resp_rdata_o, e.rd);
    chk("err", {31'b0, resp_err_o}, {31'b0, e.err});
    seen_rd = resp_rdata_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, resp_valid_o}, 32'd1);
      chk("hold_rdata", resp_rdata_o, seen_rd);
      chk("hold_ready", {31'b0, req_ready_o}, 32'd0);
      chk("hold_strobes", {30'b0, MemRead_o, MemWrite_o}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("valid_after_hs", {31'b0, resp_valid_o}, 32'd0);
    chk("ready_after_hs", {31'b0, req_ready_o}, 32'd1);
    chk("read_count", rds, exp_rds);
    chk("write_count", wrs, exp_wrs);
    if (exp_wrs == 1) chk("wr_word", seen_ww, exp_ww);
    $display("txn we=%0d f3=%0d addr=%08h wd=%08h -> rdata=%08h err=%0d lat=%0d rd=%0d wr=%0d",
             we, f3, addr, wd, seen_rd, e.err, lat, rds, wrs);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'b0, req_ready_o}, 32'd1);
    chk({tag, "_valid"}, {31'b0, resp_valid_o}, 32'd0);
    chk({tag, "_err"}, {31'b0, resp_err_o}, 32'd0);
    chk({tag, "_strobes"}, {30'b0, MemRead_o, MemWrite_o}, 32'd0);
    chk({tag, "_rdata"}, resp_rdata_o, 32'd0);
    chk({tag, "_maddr"}, MemAddr_o, 32'd0);
    chk({tag, "_mwdata"}, MemWData_o, 32'd0);
  endtask

  initial begin
    logic [2:0]  f3s [5];
    logic [2:0]  f3;
    logic [1:0]  off;
    int          wr_before;
    f3s[0] = F3_B; f3s[1] = F3_H; f3s[2] = F3_W; f3s[3] = F3_BU; f3s[4] = F3_HU;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    reset_ni = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset_ni = 1'b1;

    do_req(1'b1, F3_W, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2, 32'hDEADBEEF, 0);
    do_req(1'b0, F3_W, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 2, 32'h0, 0);

    do_req(1'b1, F3_W, 32'h8, 32'h80FF7F01, 32'h0, 1'b0, 2, 32'h80FF7F01, 0);
    do_req(1'b0, F3_B,  32'h9, 32'h0, 32'h0000007F, 1'b0, 2, 32'h0, 0);
    do_req(1'b0, F3_B,  32'hA, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 32'h0, 0);
    do_req(1'b0, F3_BU, 32'hB, 32'h0, 32'h00000080, 1'b0, 2, 32'h0, 0);
    do_req(1'b0, F3_H,  32'hA, 32'h0, 32'hFFFF80FF, 1'b0, 2, 32'h0, 0);
    do_req(1'b0, F3_HU, 32'h8, 32'h0, 32'h00007F01, 1'b0, 2, 32'h0, 0);

    do_req(1'b1, F3_W, 32'h4, 32'h11223344, 32'h0, 1'b0, 2, 32'h11223344, 0);
    do_req(1'b1, F3_B, 32'h6, 32'hFFFFFFAB, 32'h0, 1'b0, 3, 32'h11AB3344, 0);
    do_req(1'b1, F3_H, 32'h4, 32'h5555CDEF, 32'h0, 1'b0, 3, 32'h11ABCDEF, 0);
    do_req(1'b0, F3_W, 32'h4, 32'h0, 32'h11ABCDEF, 1'b0, 2, 32'h0, 0);

    do_req(1'b0, F3_W,   32'h2,  32'h0, 32'h0, 1'b1, 1, 32'h0, 0);
    do_req(1'b1, F3_H,   32'h5,  32'h1234, 32'h0, 1'b1, 1, 32'h0, 0);
    do_req(1'b0, F3_B,   32'h40, 32'h0, 32'h0, 1'b1, 1, 32'h0, 0);
    do_req(1'b0, 3'b011, 32'h0,  32'h0, 32'h0, 1'b1, 1, 32'h0, 0);
    do_req(1'b1, 3'b100, 32'h0,  32'h0, 32'h0, 1'b1, 1, 32'h0, 0);
    do_req(1'b0, F3_W,   32'h3C, 32'h0, 32'h0, 1'b0, 2, 32'h0, 0);

    do_req(1'b0, F3_W, 32'h8, 32'h0, 32'h80FF7F01, 1'b0, 2, 32'h0, 5);

    for (int i = 0; i < 6; i++) begin
      f3  = f3s[$urandom_range(0, 4)];
      off = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) off[0] = 1'b0;
      if (f3 == F3_W) off = 2'b00;
      do_req(1'b0, f3, {28'h0, 2'b10, off}, 32'h0, ref_load(f3, off, 32'h80FF7F01), 1'b0, 2, 32'h0, 0);
    end

    do_req(1'b1, F3_W, 32'hC, 32'h12345678, 32'h0, 1'b0, 2, 32'h12345678, 0);
    wr_before = wr_total;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
    req_addr = 32'hD; req_wdata = 32'hFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rst_in_rd", {31'b0, MemRead_o}, 32'd1);
    #2;
    reset_ni = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_ni = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_no_write", wr_total, wr_before);
    $display("txn reset during SB at 0x0d aborted, writes=%0d", wr_total - wr_before);
    do_req(1'b0, F3_W, 32'hC, 32'h0, 32'h12345678, 1'b0, 2, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
